// File: rtl/produto_escalar_param_if.sv
// Start/result bundle of the dot-product engine; the CSR bank is the master,
// the engine is the slave.
interface produto_escalar_param_if #(
  parameter int N     = 8,
  parameter int W     = 32,
  parameter int ACC_W = 64
);
  // Handshake: iniciar is a request, honoured on a rising edge only while
  // ocupado=0; concluido pulses for one cycle when resultado/estouro are
  // updated. Operands and mode bits only need to be valid at that edge.
  logic             iniciar;
  logic             acumular;
  logic             com_sinal;
  logic [N*W-1:0]   a_i;
  logic [N*W-1:0]   b_i;
  logic             ocupado;
  logic             concluido;
  logic [ACC_W-1:0] resultado;
  logic             estouro;

  modport master (
    output iniciar, acumular, com_sinal, a_i, b_i,
    input  ocupado, concluido, resultado, estouro
  );

  modport slave (
    input  iniciar, acumular, com_sinal, a_i, b_i,
    output ocupado, concluido, resultado, estouro
  );
endinterface

// File: rtl/produto_escalar_param.sv
// Parametrised dot-product engine folding N element pairs through LANES multipliers.
// Optional saturation/overflow reporting is enabled with `define PRODUTO_ESCALAR_SAT_EN.
module produto_escalar_param #(
  parameter int N     = 8,
  parameter int W     = 32,
  parameter int LANES = 2,
  parameter int ACC_W = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  produto_escalar_param_if.slave  bus,
  output logic [1:0]              estado_dbg
);

  localparam int P  = (N + LANES - 1) / LANES;
  localparam int CW = $clog2(P + 1);
  localparam int LW = $clog2(LANES);
`ifdef PRODUTO_ESCALAR_SAT_EN
  localparam int SUM_W = ACC_W + LW;
`else
  // Carry bits above ACC_W only matter when overflow is being detected.
  localparam int SUM_W = ACC_W;
`endif
  // One spare beat of zero padding keeps the lane slice in range while cnt==P.
  localparam int PADW = (P + 1) * LANES * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

  estado_t          estado, estado_nxt;
  logic [CW-1:0]    cnt;
  logic [N*W-1:0]   a_r, b_r;
  logic             sinal_r;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] resultado_r;
  logic             estouro_r;

  logic [PADW-1:0]  a_pad, b_pad;
  logic [W-1:0]     ea, eb;
  logic [2*W-1:0]   op_a, op_b, prod;
  logic [SUM_W-1:0] p_ext, beat_sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf;
  int               idx;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) estado <= IDLE;
    else       estado <= estado_nxt;
  end

  // Next-state logic
  always_comb begin
    estado_nxt = estado;
    case (estado)
      IDLE:    if (bus.iniciar) estado_nxt = CALC;
      CALC:    if (cnt == CW'(P)) estado_nxt = DONE;
      DONE:    estado_nxt = IDLE;
      default: estado_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.ocupado   = (estado != IDLE);
    bus.concluido = (estado == DONE);
    estado_dbg    = estado;
  end

  assign bus.resultado = resultado_r;
  assign bus.estouro   = estouro_r;

  // Products of one beat; operands are widened to 2W so the low 2W bits of
  // the product are exact in both signed and unsigned mode.
  always_comb begin
    a_pad = '0;
    b_pad = '0;
    a_pad[N*W-1:0] = a_r;
    b_pad[N*W-1:0] = b_r;
    beat_sum = '0;
    idx  = 0;
    ea   = '0;
    eb   = '0;
    op_a = '0;
    op_b = '0;
    prod = '0;
    p_ext = '0;
    for (int l = 0; l < LANES; l++) begin
      idx  = (int'(cnt) * LANES + l) * W;
      ea   = a_pad[idx +: W];
      eb   = b_pad[idx +: W];
      op_a = {{W{sinal_r & ea[W-1]}}, ea};
      op_b = {{W{sinal_r & eb[W-1]}}, eb};
      prod = op_a * op_b;
      if (sinal_r) p_ext = SUM_W'($signed(prod));
      else         p_ext = SUM_W'(prod);
      beat_sum = beat_sum + p_ext;
    end
  end

`ifdef PRODUTO_ESCALAR_SAT_EN
  localparam int T = SUM_W + 1;
  logic [T-1:0] ext_acc, ext_sum, total;
  logic         sticky;

  always_comb begin
    if (sinal_r) begin
      ext_acc = T'($signed(acc));
      ext_sum = T'($signed(beat_sum));
    end else begin
      ext_acc = T'(acc);
      ext_sum = T'(beat_sum);
    end
    total = ext_acc + ext_sum;
    if (sinal_r) begin
      // In range only when every bit from the ACC_W sign bit upward agrees.
      ovf = !((&total[T-1:ACC_W-1]) || !(|total[T-1:ACC_W-1]));
      if (ovf) acc_nxt = total[T-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else     acc_nxt = total[ACC_W-1:0];
    end else begin
      ovf = |total[T-1:ACC_W];
      if (ovf) acc_nxt = '1;
      else     acc_nxt = total[ACC_W-1:0];
    end
  end
`else
  always_comb begin
    ovf     = 1'b0;
    acc_nxt = acc + beat_sum;
  end
`endif

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      sinal_r     <= 1'b0;
      acc         <= '0;
      resultado_r <= '0;
      estouro_r   <= 1'b0;
`ifdef PRODUTO_ESCALAR_SAT_EN
      sticky      <= 1'b0;
`endif
    end else begin
      case (estado)
        IDLE: begin
          if (bus.iniciar) begin
            a_r     <= bus.a_i;
            b_r     <= bus.b_i;
            sinal_r <= bus.com_sinal;
            acc     <= bus.acumular ? resultado_r : '0;
            cnt     <= '0;
`ifdef PRODUTO_ESCALAR_SAT_EN
            sticky  <= 1'b0;
`endif
          end
        end
        CALC: begin
          if (cnt != CW'(P)) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
`ifdef PRODUTO_ESCALAR_SAT_EN
            sticky <= sticky | ovf;
`endif
          end else begin
            resultado_r <= acc;
`ifdef PRODUTO_ESCALAR_SAT_EN
            estouro_r   <= sticky;
`else
            estouro_r   <= ovf;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
